// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: count width helper, default almost-levels and the
// bundled status-flag type used by the single-clock FIFO and future variants.
package fifo_pkg;

   // Count and pointer width: one wrap bit above the memory address bits.
   function automatic int unsigned count_width(input int unsigned addr_width);
      return addr_width + 1;
   endfunction

   localparam int unsigned DefaultAddressWidth      = 4;
   localparam int unsigned DefaultAlmostFullLevel   = (1 << DefaultAddressWidth) - 2;
   localparam int unsigned DefaultAlmostEmptyLevel  = 2;

   typedef struct packed {
      logic full;
      logic almost_full;
      logic empty;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } fifo_status_t;

   localparam fifo_status_t StatusReset = '{
      full:         1'b0,
      almost_full:  1'b0,
      empty:        1'b1,
      almost_empty: 1'b1,
      overflow:     1'b0,
      underflow:    1'b0
   };

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port register array: one synchronous write port, one
// asynchronous read port. Contents are never reset.
module sync_fifo_ram #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDRESS_WIDTH = 4
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [ADDRESS_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0]    wdata_i,
   input  logic [ADDRESS_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0]    rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [1 << ADDRESS_WIDTH];

   // Store the write word on the rising edge.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO controller with fill count, almost-full/almost-empty
// flags, sticky overflow/underflow flags and synchronous clear.
// Define SYNC_FIFO_FWFT_EN for a first-word-fall-through read port; otherwise
// Data_out is registered with one cycle of read latency.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH         = 8,
   parameter int unsigned ADDRESS_WIDTH      = DefaultAddressWidth,
   parameter int unsigned ALMOST_FULL_LEVEL  = (1 << ADDRESS_WIDTH) - 2,
   parameter int unsigned ALMOST_EMPTY_LEVEL = DefaultAlmostEmptyLevel
) (
   input  logic                                   CLKIN,
   input  logic                                   Reset_in,
   input  logic                                   Clear_in,
   input  logic [DATA_WIDTH-1:0]                  Data_in,
   input  logic                                   WriteEn_in,
   output logic                                   Full_out,
   output logic                                   AlmostFull_out,
   output logic [DATA_WIDTH-1:0]                  Data_out,
   input  logic                                   ReadEn_in,
   output logic                                   Empty_out,
   output logic                                   AlmostEmpty_out,
   output logic [count_width(ADDRESS_WIDTH)-1:0]  Count_out,
   output logic                                   Overflow_out,
   output logic                                   Underflow_out
);

   localparam int unsigned FIFO_DEPTH = 1 << ADDRESS_WIDTH;
   localparam int unsigned CW         = count_width(ADDRESS_WIDTH);

   localparam logic [CW-1:0] DepthCount = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] AfLevel    = CW'(ALMOST_FULL_LEVEL);
   localparam logic [CW-1:0] AeLevel    = CW'(ALMOST_EMPTY_LEVEL);

   logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   fifo_status_t          status_q, status_d;
   logic                  wr_acc, rd_acc;
   logic [DATA_WIDTH-1:0] rd_data;

   // Accept decisions use the pre-edge flags; flags/count follow the post-edge count.
   always_comb begin
      wr_acc   = WriteEn_in & ~status_q.full;
      rd_acc   = ReadEn_in & ~status_q.empty;
      wr_ptr_d = wr_ptr_q + CW'(wr_acc);
      rd_ptr_d = rd_ptr_q + CW'(rd_acc);
      count_d  = wr_ptr_d - rd_ptr_d;

      status_d.full         = (count_d == DepthCount);
      status_d.almost_full  = (count_d >= AfLevel);
      status_d.empty        = (count_d == '0);
      status_d.almost_empty = (count_d <= AeLevel);
      status_d.overflow     = status_q.overflow | (WriteEn_in & status_q.full);
      status_d.underflow    = status_q.underflow | (ReadEn_in & status_q.empty);

      if (Clear_in) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         status_d = StatusReset;
      end
   end

   // Pointer, count and flag registers.
   always_ff @(posedge CLKIN or posedge Reset_in) begin
      if (Reset_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         status_q <= StatusReset;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         status_q <= status_d;
      end
   end

   sync_fifo_ram #(
      .DATA_WIDTH    (DATA_WIDTH),
      .ADDRESS_WIDTH (ADDRESS_WIDTH)
   ) u_ram (
      .clk_i   (CLKIN),
      .we_i    (wr_acc & ~Clear_in),
      .waddr_i (wr_ptr_q[ADDRESS_WIDTH-1:0]),
      .wdata_i (Data_in),
      .raddr_i (rd_ptr_q[ADDRESS_WIDTH-1:0]),
      .rdata_o (rd_data)
   );

`ifdef SYNC_FIFO_FWFT_EN
   // Head word falls through; forced to zero while empty so reset reads clean.
   assign Data_out = status_q.empty ? '0 : rd_data;
`else
   logic [DATA_WIDTH-1:0] dout_q;

   // Registered read port: capture the head word on each accepted read.
   always_ff @(posedge CLKIN or posedge Reset_in) begin
      if (Reset_in) begin
         dout_q <= '0;
      end else if (Clear_in) begin
         dout_q <= '0;
      end else if (rd_acc) begin
         dout_q <= rd_data;
      end
   end

   assign Data_out = dout_q;
`endif

   assign Full_out        = status_q.full;
   assign AlmostFull_out  = status_q.almost_full;
   assign Empty_out       = status_q.empty;
   assign AlmostEmpty_out = status_q.almost_empty;
   assign Overflow_out    = status_q.overflow;
   assign Underflow_out   = status_q.underflow;
   assign Count_out       = count_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised self-checking bench for sync_fifo against a queue-based model.
module tb_sync_fifo;

   logic       clk = 1'b0;
   logic       rst, clr, we, re;
   logic [7:0] din, dout;
   logic       full, afull, empty, aempty, ovf, udf;
   logic [4:0] cnt;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference model state.
   byte unsigned m_q[$];
   bit           m_ovf, m_udf;
   logic [7:0]   m_dout;

   always #5 clk = ~clk;

   sync_fifo dut (
      .CLKIN           (clk),
      .Reset_in        (rst),
      .Clear_in        (clr),
      .Data_in         (din),
      .WriteEn_in      (we),
      .Full_out        (full),
      .AlmostFull_out  (afull),
      .Data_out        (dout),
      .ReadEn_in       (re),
      .Empty_out       (empty),
      .AlmostEmpty_out (aempty),
      .Count_out       (cnt),
      .Overflow_out    (ovf),
      .Underflow_out   (udf)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_dout = 8'h00;
   endtask

   task automatic model_step(input bit w, input bit r, input bit c, input logic [7:0] d);
      bit was_full, was_empty;
      if (c) begin
         model_reset();
         return;
      end
      was_full  = (m_q.size() == 16);
      was_empty = (m_q.size() == 0);
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_udf = 1'b1;
      if (r && !was_empty) m_dout = m_q.pop_front();
      if (w && !was_full) m_q.push_back(d);
   endtask

   task automatic check_all(input string ctx);
      int n;
      n = m_q.size();
      check_eq({ctx, ":count"}, 32'(cnt), 32'(n));
      check_eq({ctx, ":full"}, 32'(full), 32'(n == 16));
      check_eq({ctx, ":afull"}, 32'(afull), 32'(n >= 14));
      check_eq({ctx, ":empty"}, 32'(empty), 32'(n == 0));
      check_eq({ctx, ":aempty"}, 32'(aempty), 32'(n <= 2));
      check_eq({ctx, ":ovf"}, 32'(ovf), 32'(m_ovf));
      check_eq({ctx, ":udf"}, 32'(udf), 32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
      if (n > 0) check_eq({ctx, ":head"}, 32'(dout), 32'(m_q[0]));
`else
      check_eq({ctx, ":dout"}, 32'(dout), 32'(m_dout));
`endif
   endtask

   // One clock: drive on the falling edge, update model at the rising edge, sample 1 later.
   task automatic cycle(input string ctx, input bit w, input bit r, input bit c,
                        input logic [7:0] d);
      @(negedge clk);
      we  = w;
      re  = r;
      clr = c;
      din = d;
      @(posedge clk);
      model_step(w, r, c, d);
      #1;
      check_all(ctx);
   endtask

   task automatic random_phase(input string ctx, input int cycles);
      int wp, rp;
      for (int i = 0; i < cycles; i++) begin
         if (i % 50 == 0) begin
            wp = $urandom_range(10, 90);
            rp = $urandom_range(10, 90);
         end
         cycle(ctx, $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
               $urandom_range(0, 99) < 2, 8'($urandom));
      end
   endtask

   initial begin
      rst = 1'b1;
      clr = 1'b0;
      we  = 1'b0;
      re  = 1'b0;
      din = 8'h00;
      model_reset();
      #12;
      rst = 1'b0;
      check_all("reset");

      // Fill to full, then one refused write.
      for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 1'b0, 1'b0, 8'(i));
      cycle("overflow", 1'b1, 1'b0, 1'b0, 8'hEE);

      // Drain in order, then one refused read.
      for (int i = 0; i < 16; i++) cycle("drain", 1'b0, 1'b1, 1'b0, 8'h00);
      cycle("underflow", 1'b0, 1'b1, 1'b0, 8'h00);
      cycle("clear_err", 1'b0, 1'b0, 1'b1, 8'h00);

      // Steady count of 5 with simultaneous read/write; pointers wrap.
      for (int i = 0; i < 5; i++) cycle("pre5", 1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
      for (int i = 0; i < 40; i++) cycle("rw5", 1'b1, 1'b1, 1'b0, 8'($urandom));

      // Full FIFO with read and write together: write refused.
      for (int i = 0; i < 11; i++) cycle("fill16", 1'b1, 1'b0, 1'b0, 8'($urandom));
      cycle("full_rw", 1'b1, 1'b1, 1'b0, 8'h77);

      // Down to 7 entries, then clear alongside a write.
      for (int i = 0; i < 8; i++) cycle("to7", 1'b0, 1'b1, 1'b0, 8'h00);
      cycle("clear_wr", 1'b1, 1'b0, 1'b1, 8'h99);
      cycle("single", 1'b1, 1'b0, 1'b0, 8'hA5);
      cycle("pop", 1'b0, 1'b1, 1'b0, 8'h00);

      random_phase("rand1", 400);

      // Asynchronous reset between clock edges.
      for (int i = 0; i < 6; i++) cycle("pre_rst", 1'b1, 1'b0, 1'b0, 8'($urandom));
      @(negedge clk);
      we = 1'b0;
      re = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst = 1'b0;

      random_phase("rand2", 300);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
